// File: rtl/regbank_wr_sched.sv
// Register-bank write-port scheduler: ALU (A) and load (B) writeback FIFOs share one
// registered write port round-robin; a per-register counter tracks writes still in flight.
module regbank_wr_sched #(
   parameter int unsigned AW      = 5,
   parameter int unsigned DW      = 32,
   parameter int unsigned DEPTH   = 2,
   parameter bit          DROP_R0 = 1'b1
) (
   input  logic          clock,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          RgW,
   output logic [AW-1:0] wrA,
   output logic [DW-1:0] wrD,
   input  logic [AW-1:0] qA,
   input  logic [AW-1:0] qB,
   output logic          pendA,
   output logic          pendB,
   output logic          idle
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned PTRW = PW + 1;
   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned CW   = $clog2(2*DEPTH+2);

   typedef enum logic {FAV_A, FAV_B} fav_e;

   logic [AW-1:0]   a_addr_mem [DEPTH];
   logic [DW-1:0]   a_data_mem [DEPTH];
   logic [AW-1:0]   b_addr_mem [DEPTH];
   logic [DW-1:0]   b_data_mem [DEPTH];
   logic [PTRW-1:0] a_wp_q, a_rp_q, b_wp_q, b_rp_q;
   logic            a_empty, a_full, b_empty, b_full;
   logic            a_store, b_store, a_pop, b_pop;
   fav_e            fav_q, fav_d;
   logic            rgw_q;
   logic [AW-1:0]   wra_q;
   logic [DW-1:0]   wrd_q;
   logic [CW-1:0]   cnt_q [NREG];
   logic [CW-1:0]   cnt_d [NREG];

   // Extra pointer MSB separates full (wrap bits differ) from empty (pointers equal).
   always_comb begin
      a_empty = (a_wp_q == a_rp_q);
      b_empty = (b_wp_q == b_rp_q);
      a_full  = (a_wp_q[PW-1:0] == a_rp_q[PW-1:0]) && (a_wp_q[PW] != a_rp_q[PW]);
      b_full  = (b_wp_q[PW-1:0] == b_rp_q[PW-1:0]) && (b_wp_q[PW] != b_rp_q[PW]);
      a_ready = rst && !a_full;
      b_ready = rst && !b_full;
      a_store = a_valid && a_ready && !(DROP_R0 && (a_addr == '0));
      b_store = b_valid && b_ready && !(DROP_R0 && (b_addr == '0));
   end

   always_comb begin
      a_pop = 1'b0;
      b_pop = 1'b0;
      fav_d = fav_q;
      if (!a_empty && !b_empty) begin
         if (fav_q == FAV_A) begin
            a_pop = 1'b1;
            fav_d = FAV_B;
         end else begin
            b_pop = 1'b1;
            fav_d = FAV_A;
         end
      end else if (!a_empty) begin
         a_pop = 1'b1;
      end else if (!b_empty) begin
         b_pop = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (a_store) begin
         a_addr_mem[a_wp_q[PW-1:0]] <= a_addr;
         a_data_mem[a_wp_q[PW-1:0]] <= a_data;
      end
      if (b_store) begin
         b_addr_mem[b_wp_q[PW-1:0]] <= b_addr;
         b_data_mem[b_wp_q[PW-1:0]] <= b_data;
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         a_wp_q <= '0;
         a_rp_q <= '0;
         b_wp_q <= '0;
         b_rp_q <= '0;
         fav_q  <= FAV_A;
         rgw_q  <= 1'b0;
         wra_q  <= '0;
         wrd_q  <= '0;
      end else begin
         if (a_store) a_wp_q <= a_wp_q + PTRW'(1);
         if (b_store) b_wp_q <= b_wp_q + PTRW'(1);
         if (a_pop)   a_rp_q <= a_rp_q + PTRW'(1);
         if (b_pop)   b_rp_q <= b_rp_q + PTRW'(1);
         fav_q <= fav_d;
         rgw_q <= a_pop || b_pop;
         if (a_pop) begin
            wra_q <= a_addr_mem[a_rp_q[PW-1:0]];
            wrd_q <= a_data_mem[a_rp_q[PW-1:0]];
         end else if (b_pop) begin
            wra_q <= b_addr_mem[b_rp_q[PW-1:0]];
            wrd_q <= b_data_mem[b_rp_q[PW-1:0]];
         end
      end
   end

   // Count drops on the commit edge, i.e. while the popped write is presented on RgW.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r]
                  + CW'(a_store && (a_addr == AW'(r)))
                  + CW'(b_store && (b_addr == AW'(r)))
                  - CW'(rgw_q && (wra_q == AW'(r)));
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign RgW   = rgw_q;
   assign wrA   = wra_q;
   assign wrD   = wrd_q;
   assign pendA = (cnt_q[qA] != '0);
   assign pendB = (cnt_q[qB] != '0);
   assign idle  = a_empty && b_empty && !rgw_q;

endmodule

// File: tb/tb_regbank_wr_sched.sv
// Randomised bench for regbank_wr_sched: a queue-based reference model predicts every
// write and pending flag; a negedge monitor compares the DUT against it.
module tb_regbank_wr_sched;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clock   = 1'b0;
   logic          rst     = 1'b0;
   logic          a_valid = 1'b0;
   logic          b_valid = 1'b0;
   logic [AW-1:0] a_addr  = '0;
   logic [AW-1:0] b_addr  = '0;
   logic [DW-1:0] a_data  = '0;
   logic [DW-1:0] b_data  = '0;
   logic [AW-1:0] qA      = '0;
   logic [AW-1:0] qB      = '0;
   logic          a_ready, b_ready, RgW, pendA, pendB, idle;
   logic [AW-1:0] wrA;
   logic [DW-1:0] wrD;

   regbank_wr_sched #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
      .clock(clock), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .RgW(RgW), .wrA(wrA), .wrD(wrD),
      .qA(qA), .qB(qB), .pendA(pendA), .pendB(pendB), .idle(idle)
   );

   always #5 clock = ~clock;

   // Reference model: FIFOs as queues, plain integer counts of writes in flight.
   wr_t         ma[$];
   wr_t         mb[$];
   wr_t         exp_q[$];
   int          mcnt [32] = '{default: 0};
   bit          mrgw      = 1'b0;
   logic [AW-1:0] mwa     = '0;
   bit          prefer_b  = 1'b0;
   int unsigned exp_base  = 0;
   int unsigned sa_n, sb_n;
   bit          take_b;
   wr_t         mw;

   always @(posedge clock or negedge rst) begin
      if (!rst) begin
         ma.delete();
         mb.delete();
         foreach (mcnt[i]) mcnt[i] = 0;
         mrgw     = 1'b0;
         prefer_b = 1'b0;
         exp_base = exp_q.size();
      end else begin
         sa_n = ma.size();
         sb_n = mb.size();
         if (mrgw) mcnt[mwa] = mcnt[mwa] - 1;
         mrgw = 1'b0;
         if (sa_n > 0 || sb_n > 0) begin
            if (sa_n > 0 && sb_n > 0) begin
               take_b   = prefer_b;
               prefer_b = !prefer_b;
            end else begin
               take_b = (sa_n == 0);
            end
            if (take_b) mw = mb.pop_front();
            else        mw = ma.pop_front();
            mrgw = 1'b1;
            mwa  = mw.addr;
            exp_q.push_back(mw);
         end
         if (a_valid && sa_n < DEPTH && a_addr != 0) begin
            mw.addr = a_addr; mw.data = a_data;
            ma.push_back(mw);
            mcnt[a_addr] = mcnt[a_addr] + 1;
         end
         if (b_valid && sb_n < DEPTH && b_addr != 0) begin
            mw.addr = b_addr; mw.data = b_data;
            mb.push_back(mw);
            mcnt[b_addr] = mcnt[b_addr] + 1;
         end
      end
   end

   int unsigned n_chk = 0, n_pass = 0, mon_idx = 0, timeouts = 0;
   bit          done = 1'b0, fin = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
   endtask

   always @(negedge clock) begin
      if (!fin) begin
         if (!rst) mon_idx = exp_base;
         chk("a_ready", a_ready, rst && (ma.size() < DEPTH));
         chk("b_ready", b_ready, rst && (mb.size() < DEPTH));
         chk("RgW", RgW, mrgw);
         if (RgW) begin
            if (mon_idx < exp_q.size()) begin
               chk("wrA", wrA, exp_q[mon_idx].addr);
               chk("wrD", wrD, exp_q[mon_idx].data);
            end else begin
               chk("unexpected_write", mon_idx, exp_q.size());
            end
            mon_idx++;
         end
         chk("pendA", pendA, mcnt[qA] != 0);
         chk("pendB", pendB, mcnt[qB] != 0);
         chk("idle", idle, (ma.size() == 0) && (mb.size() == 0) && !mrgw);
         if (done) begin
            chk("issued_count", mon_idx, exp_q.size());
            chk("drain_timeouts", timeouts, 0);
            fin = 1'b1;
         end
      end
   end

   // Stimulus: per-requester queues of writes, each held on the bus until accepted.
   wr_t         sa_q[$];
   wr_t         sb_q[$];
   int unsigned gap_a = 0, gap_b = 0;
   bit          qrand = 1'b0;

   task automatic push_a(input int unsigned ad, input int unsigned d);
      wr_t w;
      w.addr = AW'(ad); w.data = DW'(d);
      sa_q.push_back(w);
   endtask

   task automatic push_b(input int unsigned ad, input int unsigned d);
      wr_t w;
      w.addr = AW'(ad); w.data = DW'(d);
      sb_q.push_back(w);
   endtask

   task automatic drive();
      a_valid = (sa_q.size() != 0) && ($urandom_range(99) >= gap_a);
      b_valid = (sb_q.size() != 0) && ($urandom_range(99) >= gap_b);
      if (sa_q.size() != 0) begin a_addr = sa_q[0].addr; a_data = sa_q[0].data; end
      if (sb_q.size() != 0) begin b_addr = sb_q[0].addr; b_data = sb_q[0].data; end
      if (qrand) begin
         qA = AW'($urandom_range(7));
         qB = AW'($urandom_range(7));
      end
   endtask

   task automatic step();
      bit acc_a, acc_b;
      @(negedge clock);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(posedge clock);
      #1;
      if (acc_a) void'(sa_q.pop_front());
      if (acc_b) void'(sb_q.pop_front());
      drive();
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((sa_q.size() != 0 || sb_q.size() != 0 || !idle) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) timeouts++;
      step();
      step();
   endtask

   initial begin
      repeat (3) step();
      rst = 1'b1;

      qA = 5'd10; qB = 5'd7;
      push_a(10, 'h15);
      drain();

      qA = 5'd15;
      push_a(15, 'h3);
      push_b(7, 'hAA);
      drain();
      for (int unsigned i = 0; i < 6; i++) begin
         push_a(16 + i, 'h100 + i);
         push_b(24 + i, 'h200 + i);
      end
      drain();

      qA = 5'd9; qB = 5'd3;
      for (int unsigned i = 0; i < 5; i++) push_b(1 + i, 'hB0 + i);
      for (int unsigned i = 0; i < 12; i++) push_a(8 + (i % 4), 'hA0 + i);
      drain();

      qA = 5'd0;
      push_a(0, 'hFFFF);
      drain();

      qA = 5'd5;
      push_a(5, 1);
      push_a(5, 2);
      push_a(5, 3);
      drain();

      qrand = 1'b1; gap_a = 30; gap_b = 30;
      for (int unsigned i = 0; i < 400; i++) begin
         if (sa_q.size() < 2 && $urandom_range(1) == 1) push_a($urandom_range(7), $urandom);
         if (sb_q.size() < 2 && $urandom_range(1) == 1) push_b($urandom_range(7), $urandom);
         step();
      end
      drain();

      qrand = 1'b0; gap_a = 0; gap_b = 0; qA = 5'd9; qB = 5'd12;
      for (int unsigned i = 0; i < 4; i++) begin
         push_a(9, 'hC0 + i);
         push_b(12, 'hD0 + i);
      end
      repeat (3) step();
      #2;
      rst = 1'b0;
      sa_q.delete();
      sb_q.delete();
      drive();
      repeat (2) step();
      rst = 1'b1;
      repeat (10) step();

      qrand = 1'b1; gap_a = 20; gap_b = 20;
      for (int unsigned i = 0; i < 60; i++) begin
         if (sa_q.size() < 2 && $urandom_range(1) == 1) push_a($urandom_range(7), $urandom);
         if (sb_q.size() < 2 && $urandom_range(1) == 1) push_b($urandom_range(7), $urandom);
         step();
      end
      drain();

      done = 1'b1;
      for (int unsigned i = 0; i < 10 && !fin; i++) @(posedge clock);
      if (!fin) begin
         $display("FAIL monitor_final: final checks not reached, got fin=%0d expected 1", fin);
         $fatal(1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
